sub_32_serial: RTL and testbench

Multi-cycle 32-bit subtractor for the ALU32_MIPS datapath, the inverse of the 32-bit byte-sliced adder. Computes out = in0 - in1 - bin one 8-bit slice per cycle, LSB slice first, rippling a registered borrow between slices. Uses a start/busy/done handshake. Also produces borrow, signed-overflow and zero flags for SUB/SUBU/SLT/BEQ use.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/sub_32_serial_if.sv | 25 ++
 rtl/sub_32_serial_sub_8.sv | 21 ++
 rtl/sub_32_serial.sv | 116 +++++++++++
 tb/tb_sub_32_serial.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared constants and types for the byte-sliced serial subtractor.
package alu_pkg;

  localparam int unsigned WIDTH    = 32;
  localparam int unsigned SLICE_W  = 8;
  localparam int unsigned N_SLICES = WIDTH / SLICE_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Result flags, all registered together on the final slice edge
  typedef struct packed {
    logic borrow;
    logic overflow;
    logic zero;
  } flags_t;

endpackage

// File: rtl/sub_32_serial_if.sv
// start/busy/done handshake plus operand and result bus of the serial subtractor.
interface sub_32_serial_if #(
  parameter int unsigned WIDTH = alu_pkg::WIDTH
);
  logic             start;
  logic [WIDTH-1:0] in0;
  logic [WIDTH-1:0] in1;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] out;
  logic             borrowout;
  logic             overflow;
  logic             zero;

  modport master (
    output start, in0, in1, bin,
    input  busy, done, out, borrowout, overflow, zero
  );

  modport slave (
    input  start, in0, in1, bin,
    output busy, done, out, borrowout, overflow, zero
  );
endinterface

// File: rtl/sub_32_serial_sub_8.sv
// Combinational slice subtractor: {borrowout, d} = a - b - bin.
module sub_8
  import alu_pkg::*;
#(
  parameter int unsigned W = SLICE_W
) (
  input  logic         bin,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         borrowout,
  output logic [W-1:0] d
);

  // One extra bit catches the wrap below zero as the borrow
  logic [W:0] diff;

  assign diff      = {1'b0, a} - {1'b0, b} - (W+1)'(bin);
  assign borrowout = diff[W];
  assign d         = diff[W-1:0];

endmodule

// File: rtl/sub_32_serial.sv
// Multi-cycle subtractor: one slice per cycle, LSB first, with a registered borrow ripple.
module sub_32_serial
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH   = alu_pkg::WIDTH,
  parameter int unsigned SLICE_W = alu_pkg::SLICE_W
) (
  input  logic            clk,
  input  logic            rst_n,
  sub_32_serial_if.slave  bus
);

  localparam int unsigned NS    = WIDTH / SLICE_W;
  localparam int unsigned IDX_W = (NS > 1) ? $clog2(NS) : 1;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               borrow_q, borrow_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]   out_q, out_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  flags_t             flags_q, flags_d;

  logic [SLICE_W-1:0] slice_a;
  logic [SLICE_W-1:0] slice_b;
  logic [SLICE_W-1:0] slice_d;
  logic               slice_bo;
  logic               last_slice;

  // Single slice subtractor shared across cycles through the idx mux
  assign slice_a    = a_q[idx_q*SLICE_W +: SLICE_W];
  assign slice_b    = b_q[idx_q*SLICE_W +: SLICE_W];
  assign last_slice = (idx_q == IDX_W'(NS - 1));

  sub_8 #(.W(SLICE_W)) u_slice (
    .bin       (borrow_q),
    .a         (slice_a),
    .b         (slice_b),
    .borrowout (slice_bo),
    .d         (slice_d)
  );

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    borrow_d = borrow_q;
    idx_d    = idx_q;
    out_d    = out_q;
    done_d   = 1'b0;
    flags_d  = flags_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_d      = bus.in0;
          b_d      = bus.in1;
          borrow_d = bus.bin;
          idx_d    = '0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        out_d[idx_q*SLICE_W +: SLICE_W] = slice_d;
        borrow_d = slice_bo;
        idx_d    = IDX_W'(idx_q + 1'b1);
        if (last_slice) begin
          state_d          = S_DONE;
          done_d           = 1'b1;
          flags_d.borrow   = slice_bo;
          flags_d.overflow = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                             (out_d[WIDTH-1] != a_q[WIDTH-1]);
          flags_d.zero     = (out_d == '0);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      borrow_q <= 1'b0;
      idx_q    <= '0;
      out_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      borrow_q <= borrow_d;
      idx_q    <= idx_d;
      out_q    <= out_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      flags_q  <= flags_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.out       = out_q;
  assign bus.borrowout = flags_q.borrow;
  assign bus.overflow  = flags_q.overflow;
  assign bus.zero      = flags_q.zero;

endmodule

// File: tb/tb_sub_32_serial.sv
// Randomized and directed bench for sub_32_serial against a protocol-level arithmetic model.
module tb_sub_32_serial;

  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  sub_32_serial_if #(.WIDTH(W)) bus ();

  sub_32_serial #(.WIDTH(W), .SLICE_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic straight from the definition of a - b - bin
  function automatic void ref_sub(input logic [31:0] a, input logic [31:0] b, input logic bi,
                                  output logic [31:0] r, output logic bo,
                                  output logic ov, output logic z);
    longint sr;
    r  = a - b - 32'(bi);
    bo = ({2'b00, a} < ({2'b00, b} + 34'(bi)));
    sr = longint'($signed(a)) - longint'($signed(b)) - longint'(bi);
    ov = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    z  = (r == 32'd0);
  endfunction

  // Model: phase counts edges since acceptance (0 = idle, 5 = done cycle)
  int          phase;
  logic [31:0] m_out, p_out;
  logic        m_bo, m_ov, m_z, p_bo, p_ov, p_z;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= 0;
      m_out <= '0; m_bo <= 1'b0; m_ov <= 1'b0; m_z <= 1'b0;
      p_out <= '0; p_bo <= 1'b0; p_ov <= 1'b0; p_z <= 1'b0;
    end else if (phase == 0) begin
      if (bus.start) begin
        logic [31:0] r; logic bo, ov, z;
        ref_sub(bus.in0, bus.in1, bus.bin, r, bo, ov, z);
        p_out <= r; p_bo <= bo; p_ov <= ov; p_z <= z;
        phase <= 1;
      end
    end else if (phase == 5) begin
      phase <= 0;
    end else begin
      phase <= phase + 1;
      if (phase == 4) begin
        m_out <= p_out; m_bo <= p_bo; m_ov <= p_ov; m_z <= p_z;
      end
    end
  end

  // Cycle-by-cycle comparison of handshake, flags and (when meaningful) the result
  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy", 32'(bus.busy), 32'(phase != 0));
      chk("done", 32'(bus.done), 32'(phase == 5));
      chk("borrowout", 32'(bus.borrowout), 32'(m_bo));
      chk("overflow", 32'(bus.overflow), 32'(m_ov));
      chk("zero", 32'(bus.zero), 32'(m_z));
      if (phase == 0 || phase == 5) chk("out", bus.out, m_out);
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!bus.busy) return;
    end
    chk("idle_timeout", 32'(bus.busy), 32'd0);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.done) return;
    end
    chk("done_timeout", 32'(bus.done), 32'd1);
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic bi);
    @(posedge clk); #1;
    bus.in0 = a; bus.in1 = b; bus.bin = bi; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  // Literal expectations checked against both DUT and model
  task automatic check_lit(input string name, input logic [31:0] eo,
                           input logic eb, input logic ev, input logic ez);
    chk({name, "_out"}, bus.out, eo);
    chk({name, "_bo"}, 32'(bus.borrowout), 32'(eb));
    chk({name, "_ov"}, 32'(bus.overflow), 32'(ev));
    chk({name, "_z"}, 32'(bus.zero), 32'(ez));
    chk({name, "_model_out"}, m_out, eo);
    chk({name, "_model_flags"}, {29'd0, m_bo, m_ov, m_z}, {29'd0, eb, ev, ez});
  endtask

  task automatic directed(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic bi, input logic [31:0] eo,
                          input logic eb, input logic ev, input logic ez);
    wait_idle();
    issue(a, b, bi);
    wait_done();
    check_lit(name, eo, eb, ev, ez);
  endtask

  logic [31:0] specials [6] = '{32'h0, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h1, 32'h00010000};

  initial begin
    bus.start = 1'b0; bus.in0 = '0; bus.in1 = '0; bus.bin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_out", bus.out, 32'd0);
    chk("rst_flags", {29'd0, bus.borrowout, bus.overflow, bus.zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    directed("basic", 32'h5, 32'h3, 1'b0, 32'h2, 1'b0, 1'b0, 1'b0);
    directed("underflow", 32'h0, 32'h1, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0);
    directed("ovf_neg", 32'h80000000, 32'h1, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0);
    directed("ovf_pos", 32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h80000000, 1'b1, 1'b1, 1'b0);
    directed("xslice", 32'h00010000, 32'h1, 1'b0, 32'h0000FFFF, 1'b0, 1'b0, 1'b0);
    directed("equal", 32'h12345678, 32'h12345678, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    directed("equal_bin", 32'h12345678, 32'h12345678, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0);

    // Starts while busy are ignored; a start held through DONE is taken once idle
    wait_idle();
    issue(32'h64, 32'h1, 1'b0);
    bus.start = 1'b1; bus.in0 = 32'hDEAD; bus.in1 = 32'hBEEF;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.in0 = 32'h10; bus.in1 = 32'h20; bus.bin = 1'b0;
    wait_done();
    check_lit("hs_first", 32'h63, 1'b0, 1'b0, 1'b0);
    wait_done();
    bus.start = 1'b0;
    check_lit("hs_second", 32'hFFFFFFF0, 1'b1, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a run
    wait_idle();
    issue(32'hFFFFFFFF, 32'h0, 1'b0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_done", 32'(bus.done), 32'd0);
    chk("mid_rst_out", bus.out, 32'd0);
    chk("mid_rst_flags", {29'd0, bus.borrowout, bus.overflow, bus.zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    directed("after_rst", 32'h9, 32'h4, 1'b0, 32'h5, 1'b0, 1'b0, 1'b0);

    // Random operations with random start noise while busy
    for (int n = 0; n < 300; n++) begin
      logic [31:0] a, b;
      a = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
      b = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
      if ($urandom_range(0, 7) == 0) b = a;
      wait_idle();
      repeat ($urandom_range(0, 2)) @(posedge clk);
      issue(a, b, 1'($urandom_range(0, 1)));
      for (int i = 0; i < 20; i++) begin
        bus.start = 1'($urandom_range(0, 1));
        bus.in0 = $urandom; bus.in1 = $urandom; bus.bin = 1'($urandom_range(0, 1));
        @(negedge clk);
        if (bus.done) break;
        @(posedge clk); #1;
        if (i == 19) chk("rand_done_timeout", 32'(bus.done), 32'd1);
      end
      bus.start = 1'b0;
    end

    wait_idle();
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
